// File: rtl/burst_desc_partition.sv
// Splits {id, addr, len_m1} descriptors into PLEN-beat chunks queued in an output
// FIFO, with optional partition-pulse gating and drain-then-wait-last completion.
module burst_desc_partition #(
  parameter int PLEN       = 128,
  parameter int LSIZE      = 12,
  parameter int ASIZE      = 24,
  parameter int IDSIZE     = 4,
  parameter int SEQSIZE    = 3,
  parameter int ADDR_INC   = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int PP_EN      = 1,
  parameter int WL_EN      = 1,
  parameter int TMO        = 1000
) (
  input  logic                                  clock,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IDSIZE+ASIZE+LSIZE-1:0]         in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SEQSIZE+IDSIZE+ASIZE+LSIZE:0]   out_data,
  output logic                                  pp_valid,
  input  logic                                  pp_ready,
  output logic                                  wl_valid,
  input  logic                                  wl_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
  output logic                                  busy,
  output logic                                  stall_err
);
  localparam int DW  = SEQSIZE + 1 + IDSIZE + ASIZE + LSIZE;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(TMO + 2);
  localparam logic [LSIZE-1:0] PLEN_L  = LSIZE'(PLEN);
  localparam logic [LSIZE-1:0] PLEN_M1 = LSIZE'(PLEN - 1);
  localparam logic [WDW-1:0]   WD_LIM  = WDW'(TMO);
  localparam logic [WDW-1:0]   WD_MAX  = WDW'(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_PUSH, S_LAST, S_DRAIN, S_WAIT
  } state_t;

  state_t             state, state_nx;
  logic [IDSIZE-1:0]  id_q;
  logic [ASIZE-1:0]   addr_q;
  logic [LSIZE-1:0]   rem_q;
  logic [LSIZE-1:0]   rem_nx;
  logic [SEQSIZE-1:0] seq_q;
  logic [WDW-1:0]     wd_cnt;
  logic               in_fire, wr_en, rd_en, full, empty, wd_active;
  logic               rem_lt, rem_nx_lt;
  logic [DW-1:0]      wr_data;
  logic [DW-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Fullness is judged on the registered count, so a same-cycle read never frees a slot.
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign rd_en      = out_valid && out_ready;
  assign out_valid  = !empty;
  assign out_data   = mem[rd_ptr];
  assign fifo_count = count;
  assign in_ready   = (state == S_IDLE) && !rst;
  assign in_fire    = in_valid && in_ready;
  assign busy       = (state != S_IDLE);
  assign rem_nx     = rem_q - PLEN_L;
  assign rem_lt     = (32'(rem_q) < 32'(PLEN));
  assign rem_nx_lt  = (32'(rem_nx) < 32'(PLEN));
  assign wd_active  = (state == S_REQ) || (state == S_WAIT);

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    wr_data  = '0;
    pp_valid = 1'b0;
    wl_valid = 1'b0;
    case (state)
      S_IDLE:  if (in_fire) state_nx = S_LOAD;
      S_LOAD:  state_nx = rem_lt ? S_LAST : ((PP_EN != 0) ? S_REQ : S_PUSH);
      S_REQ: begin
        pp_valid = 1'b1;
        if (pp_ready) state_nx = S_PUSH;
      end
      S_PUSH: if (!full) begin
        wr_en    = 1'b1;
        wr_data  = {seq_q, 1'b0, id_q, addr_q, PLEN_M1};
        state_nx = rem_nx_lt ? S_LAST : ((PP_EN != 0) ? S_REQ : S_PUSH);
      end
      S_LAST: if (!full) begin
        wr_en    = 1'b1;
        wr_data  = {seq_q, 1'b1, id_q, addr_q, rem_q};
        state_nx = (WL_EN != 0) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: if (empty) state_nx = S_WAIT;
      S_WAIT: begin
        wl_valid = 1'b1;
        if (wl_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      id_q   <= '0;
      addr_q <= '0;
      rem_q  <= '0;
      seq_q  <= '0;
    end else begin
      state <= state_nx;
      if (in_fire) begin
        {id_q, addr_q, rem_q} <= in_data;
        seq_q <= '0;
      end else if (state == S_PUSH && !full) begin
        rem_q  <= rem_nx;
        addr_q <= addr_q + ASIZE'(ADDR_INC);
        seq_q  <= seq_q + SEQSIZE'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Counter saturates just past the limit; the flag is sticky until a new descriptor.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else begin
      if (!wd_active)            wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WDW'(1);
      if (in_fire)                            stall_err <= 1'b0;
      else if (wd_active && wd_cnt >= WD_LIM) stall_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_burst_desc_partition.sv
// Directed bench: instance A (defaults, short watchdog) and instance B
// (2-deep FIFO, no partition pulse, no wait-last).
module tb_burst_desc_partition;
  localparam int TMO_T = 20;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic        pp_valid_a, pp_ready_a, wl_valid_a, wl_ready_a, busy_a, stall_err_a;
  logic [39:0] in_data_a;
  logic [43:0] out_data_a;
  logic [3:0]  fifo_count_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic        pp_valid_b, pp_ready_b, wl_valid_b, wl_ready_b, busy_b, stall_err_b;
  logic [39:0] in_data_b;
  logic [43:0] out_data_b;
  logic [1:0]  fifo_count_b;

  burst_desc_partition #(.TMO(TMO_T)) u_a (
    .clock(clock), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .pp_valid(pp_valid_a), .pp_ready(pp_ready_a),
    .wl_valid(wl_valid_a), .wl_ready(wl_ready_a),
    .fifo_count(fifo_count_a), .busy(busy_a), .stall_err(stall_err_a)
  );

  burst_desc_partition #(.FIFO_DEPTH(2), .PP_EN(0), .WL_EN(0), .TMO(TMO_T)) u_b (
    .clock(clock), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .pp_valid(pp_valid_b), .pp_ready(pp_ready_b),
    .wl_valid(wl_valid_b), .wl_ready(wl_ready_b),
    .fifo_count(fifo_count_b), .busy(busy_b), .stall_err(stall_err_b)
  );

  logic [43:0] qa[$];
  logic [43:0] qb[$];
  int          qa_pp[$];
  int          ppcnt_a = 0;
  int          wlcnt_a = 0;

  always @(posedge clock) begin
    if (out_valid_a && out_ready_a) begin
      qa.push_back(out_data_a);
      qa_pp.push_back(ppcnt_a);
    end
    if (pp_valid_a && pp_ready_a) ppcnt_a <= ppcnt_a + 1;
    if (wl_valid_a && wl_ready_a) wlcnt_a <= wlcnt_a + 1;
    if (out_valid_b && out_ready_b) qb.push_back(out_data_b);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [3:0] id, input logic [23:0] addr, input logic [11:0] len);
    int n = 0;
    in_valid_a = 1'b1;
    in_data_a  = {id, addr, len};
    while (!in_ready_a && n < 200) begin @(negedge clock); n++; end
    chk("send_a_ready", {63'b0, in_ready_a}, 64'd1);
    @(negedge clock);
    in_valid_a = 1'b0;
  endtask

  task automatic wait_wl_a(input int base);
    int n = 0;
    while (wlcnt_a == base && n < 800) begin @(negedge clock); n++; end
    chk("wl_handshake", 64'(wlcnt_a - base), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [23:0] addr;
    logic [11:0] len;
    int          n;
    int          pp;
    int          pp_first;
    logic [11:0] last_len;
    logic [23:0] last_addr;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          bq, bpp, bwl, n;
    logic        lst;
    logic [2:0]  sq;
    logic [43:0] e, head;

    vt[0] = '{4'h1, 24'h000010, 12'd100,  1,  0, 0, 12'd100, 24'h000010};
    vt[1] = '{4'h2, 24'h000200, 12'd255,  2,  1, 1, 12'd127, 24'h000201};
    vt[2] = '{4'h3, 24'hFFFFFF, 12'd128,  2,  1, 1, 12'd0,   24'h000000};
    vt[3] = '{4'h4, 24'h000005, 12'd0,    1,  0, 0, 12'd0,   24'h000005};
    vt[4] = '{4'h5, 24'h000100, 12'd127,  1,  0, 0, 12'd127, 24'h000100};
    vt[5] = '{4'h6, 24'h000040, 12'd4095, 32, 31, 1, 12'd127, 24'h00005F};
    vt[6] = '{4'h7, 24'h000007, 12'd300,  3,  2, 1, 12'd44,  24'h000009};

    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0; pp_ready_a = 1'b0; wl_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0; pp_ready_b = 1'b0; wl_ready_b = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready_a",  {63'b0, in_ready_a},  64'd0);
    chk("rst_out_valid_a", {63'b0, out_valid_a}, 64'd0);
    chk("rst_pp_valid_a",  {63'b0, pp_valid_a},  64'd0);
    chk("rst_wl_valid_a",  {63'b0, wl_valid_a},  64'd0);
    chk("rst_busy_a",      {63'b0, busy_a},      64'd0);
    chk("rst_stall_a",     {63'b0, stall_err_a}, 64'd0);
    chk("rst_count_a",     64'(fifo_count_a),    64'd0);
    chk("rst_out_data_a",  64'(out_data_a),      64'd0);
    chk("rst_in_ready_b",  {63'b0, in_ready_b},  64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_a", {63'b0, in_ready_a}, 64'd1);
    chk("rel_in_ready_b", {63'b0, in_ready_b}, 64'd1);
    @(negedge clock);

    out_ready_a = 1'b1; pp_ready_a = 1'b1; wl_ready_a = 1'b1;
    for (int v = 0; v < 7; v++) begin
      bq = qa.size(); bpp = ppcnt_a; bwl = wlcnt_a;
      send_a(vt[v].id, vt[v].addr, vt[v].len);
      wait_wl_a(bwl);
      chk($sformatf("v%0d_chunks", v), 64'(qa.size() - bq), 64'(vt[v].n));
      chk($sformatf("v%0d_pp", v), 64'(ppcnt_a - bpp), 64'(vt[v].pp));
      if (qa.size() > bq)
        chk($sformatf("v%0d_pp_first", v), 64'(qa_pp[bq] - bpp), 64'(vt[v].pp_first));
      chk($sformatf("v%0d_idle", v), {63'b0, busy_a}, 64'd0);
      for (int i = 0; i < vt[v].n && bq + i < qa.size(); i++) begin
        lst = (i == vt[v].n - 1);
        sq  = 3'(i);
        e   = {sq, lst, vt[v].id, lst ? vt[v].last_addr : 24'(vt[v].addr + 24'(i)),
               lst ? vt[v].last_len : 12'd127};
        chk($sformatf("v%0d_chunk%0d", v, i), 64'(qa[bq + i]), 64'(e));
      end
    end

    // Watchdog: partition pulse withheld well past the limit.
    pp_ready_a = 1'b0;
    bwl = wlcnt_a;
    send_a(4'h8, 24'h000300, 12'd255);
    repeat (5) @(negedge clock);
    chk("wd_pp_valid", {63'b0, pp_valid_a},  64'd1);
    chk("wd_early",    {63'b0, stall_err_a}, 64'd0);
    repeat (TMO_T) @(negedge clock);
    chk("wd_set", {63'b0, stall_err_a}, 64'd1);
    pp_ready_a = 1'b1;
    wait_wl_a(bwl);
    chk("wd_sticky", {63'b0, stall_err_a}, 64'd1);
    bwl = wlcnt_a;
    send_a(4'h9, 24'h000500, 12'd10);
    chk("wd_clear", {63'b0, stall_err_a}, 64'd0);
    wait_wl_a(bwl);

    // B: long descriptor against a 2-deep FIFO with the sink stalled.
    in_valid_b = 1'b1; in_data_b = {4'h9, 24'h001000, 12'd1023};
    n = 0;
    while (!in_ready_b && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    in_valid_b = 1'b0;
    repeat (10) @(negedge clock);
    head = {3'd0, 1'b0, 4'h9, 24'h001000, 12'd127};
    chk("b_stall_count", 64'(fifo_count_b),    64'd2);
    chk("b_stall_busy",  {63'b0, busy_b},      64'd1);
    chk("b_stall_ready", {63'b0, in_ready_b},  64'd0);
    chk("b_stall_valid", {63'b0, out_valid_b}, 64'd1);
    chk("b_stall_head",  64'(out_data_b),      64'(head));
    repeat (3) @(negedge clock);
    chk("b_head_stable", 64'(out_data_b), 64'(head));
    bq = qb.size();
    out_ready_b = 1'b1;
    n = 0;
    while (qb.size() - bq < 8 && n < 200) begin @(negedge clock); n++; end
    repeat (3) @(negedge clock);
    chk("b_long_chunks", 64'(qb.size() - bq), 64'd8);
    for (int i = 0; i < 8 && bq + i < qb.size(); i++) begin
      sq = 3'(i);
      e  = {sq, (i == 7), 4'h9, 24'(24'h001000 + 24'(i)), 12'd127};
      chk($sformatf("b_long_chunk%0d", i), 64'(qb[bq + i]), 64'(e));
    end
    chk("b_long_idle", {63'b0, in_ready_b}, 64'd1);

    // B: back-to-back descriptors, second held valid from the first handshake on.
    bq = qb.size();
    in_valid_b = 1'b1; in_data_b = {4'hA, 24'h000020, 12'd200};
    n = 0;
    while (!in_ready_b && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    in_data_b = {4'hB, 24'h000030, 12'd50};
    n = 1;
    while (!in_ready_b && n < 50) begin @(negedge clock); n++; end
    chk("b2b_gap", 64'(n), 64'd4);
    @(negedge clock);
    in_valid_b = 1'b0;
    repeat (10) @(negedge clock);
    chk("b2b_chunks", 64'(qb.size() - bq), 64'd3);
    if (qb.size() >= bq + 3) begin
      chk("b2b_c0", 64'(qb[bq]),     64'({3'd0, 1'b0, 4'hA, 24'h000020, 12'd127}));
      chk("b2b_c1", 64'(qb[bq + 1]), 64'({3'd1, 1'b1, 4'hA, 24'h000021, 12'd72}));
      chk("b2b_c2", 64'(qb[bq + 2]), 64'({3'd0, 1'b1, 4'hB, 24'h000030, 12'd50}));
    end

    // A: reset pulse while the third chunk is being produced.
    out_ready_a = 1'b0; pp_ready_a = 1'b1;
    send_a(4'hC, 24'h000400, 12'd1023);
    n = 0;
    while (fifo_count_a != 4'd2 && n < 50) begin @(negedge clock); n++; end
    chk("mid_count_pre", 64'(fifo_count_a), 64'd2);
    @(negedge clock);
    bq = qa.size();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'b0, out_valid_a}, 64'd0);
    chk("mid_rst_count", 64'(fifo_count_a),    64'd0);
    chk("mid_rst_ready", {63'b0, in_ready_a},  64'd0);
    @(negedge clock);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", {63'b0, in_ready_a},  64'd1);
    chk("mid_rel_valid", {63'b0, out_valid_a}, 64'd0);
    chk("mid_rel_count", 64'(fifo_count_a),    64'd0);
    chk("mid_rel_busy",  {63'b0, busy_a},      64'd0);
    out_ready_a = 1'b1;
    repeat (10) @(negedge clock);
    chk("mid_no_chunks", 64'(qa.size() - bq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/burst_desc_partition.md
BURST_DESC_PARTITION -- requirements
Module: burst_desc_partition

Interface
REQ-001 SHALL have parameter PLEN, default 128, meaning max beats per output chunk; must be a power of two and >=2.
REQ-002 SHALL have parameter LSIZE, default 12, meaning width of the length-minus-one field.
REQ-003 SHALL have parameter ASIZE, default 24, meaning address field width.
REQ-004 SHALL have parameter IDSIZE, default 4, meaning descriptor ID width.
REQ-005 SHALL have parameter SEQSIZE, default 3, meaning chunk sequence-number width.
REQ-006 SHALL have parameter ADDR_INC, default 1, meaning amount added to the address per chunk.
REQ-007 SHALL have parameter FIFO_DEPTH, default 8, meaning output FIFO entries; must be >=2.
REQ-008 SHALL have parameters PP_EN and WL_EN, both default 1, meaning: enable partition-pulse gating; enable drain-and-wait-last completion.
REQ-009 SHALL have parameter TMO, default 1000, meaning stall watchdog limit in cycles.
REQ-010 SHALL have one clock; reset is asynchronous and active-high.
REQ-011 SHALL have ports:
- clock  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid/in_ready  in/out  1  descriptor handshake
- in_data  in  IDSIZE+ASIZE+LSIZE  {id, addr, len_m1}
- out_valid/out_ready  out/in  1  chunk handshake
- out_data  out  SEQSIZE+1+IDSIZE+ASIZE+LSIZE  {seq, last, id, addr, len_m1}
- pp_valid/pp_ready  out/in  1  partition-pulse request
- wl_valid/wl_ready  out/in  1  wait-last request
- fifo_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- busy  out  1  high whenever state != IDLE
- stall_err  out  1  sticky watchdog flag

Function
REQ-012 SHALL implement states IDLE, LOAD, REQ, PUSH, LAST, DRAIN, WAIT.
REQ-013 SHALL drive in_ready high only in IDLE; an in handshake latches in_data into id/addr/rem and moves to LOAD.
REQ-014 LOAD SHALL go to LAST if rem<PLEN; otherwise to REQ when PP_EN=1, or to PUSH when PP_EN=0.
REQ-015 REQ SHALL hold pp_valid high with pp_data absent; a pp handshake moves to PUSH.
REQ-016 PUSH SHALL write {seq, 0, id, addr, PLEN-1} to the FIFO in the first cycle it is not full, then:
- rem -= PLEN; addr += ADDR_INC (modulo 2^ASIZE); seq += 1 (modulo 2^SEQSIZE);
- next state LAST if the new rem < PLEN, else REQ (PP_EN=1) or PUSH (PP_EN=0).
REQ-017 LAST SHALL write {seq, 1, id, addr, rem} when not full; then go to DRAIN if WL_EN=1, else to IDLE.
REQ-018 Chunk count SHALL be floor(len_m1/PLEN)+1; the sum of (len_m1+1) over all chunks SHALL equal the input len_m1+1.
REQ-019 seq SHALL reset to 0 at every new descriptor.
REQ-020 DRAIN SHALL go to WAIT when the FIFO is empty.
REQ-021 WAIT SHALL hold wl_valid high; a wl handshake returns to IDLE.
REQ-022 FIFO rules:
- out_valid = ~empty; out_data is the head entry and SHALL remain stable while out_valid && ~out_ready.
- A write is blocked only when count==FIFO_DEPTH at the start of the cycle; a simultaneous read does not free the slot in the same cycle.
- Simultaneous read and write when not full SHALL leave count unchanged.
REQ-023 Watchdog:
- The counter increments each cycle in REQ or WAIT and clears on leaving them.
- stall_err SHALL set when the counter exceeds TMO and stay set until the next in handshake.
REQ-024 With WL_EN=0, in_ready SHALL reassert the cycle after the LAST write, allowing back-to-back descriptors while the FIFO drains.

Reset
REQ-025 Reset SHALL force: state IDLE, FIFO empty, in_ready 0 during reset and 1 on the first cycle after release; out_valid, pp_valid, wl_valid, busy, stall_err 0; fifo_count 0; all data registers 0.
REQ-026 Reset asserted mid-descriptor SHALL discard all queued chunks, and no partial chunk SHALL appear after release.

Verification
REQ-027 PLEN=128, len_m1=100, addr=0x10: exactly one chunk {seq0, last1, addr0x10, len100}; no pp_valid; then wl_valid after the drain.
REQ-028 len_m1=255, PP_EN=1: chunks are {0, 0, A, 127} and then {1, 1, A+1, 127}; exactly one pp handshake precedes the first chunk.
REQ-029 len_m1=1023, FIFO_DEPTH=2, out_ready=0: two chunks are queued, fifo_count=2 and the block stalls; releasing out_ready yields 8 chunks with seq 0..7, only the last flagged.
REQ-030 WL_EN=0, two back-to-back descriptors: in_ready returns 1 cycle after the first descriptor's LAST write, and outputs keep the order of the input descriptors.
REQ-031 pp_ready held 0 for TMO+1 cycles: stall_err=1, and it clears on the next in handshake.
REQ-032 Reset pulse in the middle of the third chunk: out_valid=0, fifo_count=0, in_ready=1 after release.
